// File: rtl/apb_requester_if.sv
// Purpose : bundles the command/response stream and the APB bus of apb_requester.
// Latency : none, wires only.
// Backpressure: cmd_* uses valid/ready; rsp_* is a one-cycle pulse with no ready.
//
// Ports carried:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command stream
//   rsp_valid/rsp_rdata/rsp_error                     response pulse
//   paddr/pwdata/pwrite/psel/penable/prdata/pready    APB requester side
//
// master : the requester's view (drives cmd_ready, rsp_*, APB controls).
// slave  : the surrounding agent/target's view.
interface apb_requester_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             paddr, pwdata, pwrite, psel, penable
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             paddr, pwdata, pwrite, psel, penable
   );
endinterface

// File: rtl/apb_requester.sv
// Purpose : single-outstanding APB requester; one command in, one SETUP/ACCESS
//           transfer out, one response pulse back (read data + timeout error).
// Latency : accept at edge k -> rsp_valid in cycle k+3 (write, or read with
//           RD_DELAY=0) or k+4 (read, RD_DELAY=1); +1 per pready=0 cycle.
// Backpressure: cmd_ready only in IDLE, no buffering; responses cannot be stalled.
//
// Ports:
//   pclk     APB clock, the only clock
//   presetn  asynchronous active-low reset; aborts any transfer silently
//   bus      apb_requester_if.master: cmd_*, rsp_*, and the APB signals
//
// Parameters:
//   RD_DELAY  0: prdata sampled on the completing ACCESS edge;
//             1: sampled one cycle later (targets with registered read data)
//   TIMEOUT   consecutive pready=0 ACCESS cycles before abort; 0 disables
module apb_requester #(
   parameter int unsigned RD_DELAY = 1,
   parameter int unsigned TIMEOUT  = 16
) (
   input logic             pclk,
   input logic             presetn,
   apb_requester_if.master bus
);

   // Counter wide enough to hold TIMEOUT-1; at least one bit.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit          TO_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ACCESS  = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   paddr_q;
   logic [31:0]   pwdata_q;
   logic          pwrite_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [CW-1:0] wait_cnt;

   // Per-cycle strobes produced by the next-state logic.
   logic accept;     // command taken in IDLE
   logic cap_rd;     // sample prdata into the response register
   logic abort;      // timeout reached: flag error, drop data
   logic wait_inc;   // another pready=0 ACCESS cycle
   logic done;       // RESP -> IDLE: clear per-transfer state

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cap_rd    = 1'b0;
      abort     = 1'b0;
      wait_inc  = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            // pready wins over a timeout landing in the same cycle.
            if (bus.pready) begin
               if (pwrite_q) begin
                  state_nxt = RESP;
               end else if (RD_DELAY == 0) begin
                  cap_rd    = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = CAPTURE;
               end
            end else if (TO_EN && (wait_cnt == TO_LAST)) begin
               // This is the TIMEOUT-th consecutive wait cycle.
               abort     = 1'b1;
               state_nxt = RESP;
            end else begin
               wait_inc = 1'b1;
            end
         end
         CAPTURE: begin
            cap_rd    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Address/data/direction change only on acceptance and hold otherwise.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
      end else if (accept) begin
         paddr_q  <= bus.cmd_addr;
         pwdata_q <= bus.cmd_wdata;
         pwrite_q <= bus.cmd_write;
      end
   end

   // Response data stays 0 except after a read capture, so writes and
   // timeouts report 0 without extra muxing.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (cap_rd) begin
            rdata_q <= bus.prdata;
         end else if (abort || done) begin
            rdata_q <= '0;
         end

         if (abort) begin
            err_q <= 1'b1;
         end else if (done) begin
            err_q <= 1'b0;
         end

         if (done) begin
            wait_cnt <= '0;
         end else if (wait_inc && TO_EN) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

   // Bus controls decode straight from state so reset drops psel/penable at once.
   assign bus.cmd_ready = (state == IDLE);
   assign bus.psel      = (state == SETUP) || (state == ACCESS);
   assign bus.penable   = (state == ACCESS);
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Purpose : directed self-checking bench for apb_requester with a small
//           register target (0x0..0x10, offset 0x0 implements 4 bits only).
// Latency : expectations are hand-computed cycle offsets from acceptance.
// Backpressure: target wait states and a stuck-low pready are injected.
module tb_apb_requester;
   localparam int unsigned TIMEOUT = 16;

   logic pclk    = 1'b0;
   logic presetn = 1'b1;
   always #5 pclk = ~pclk;

   apb_requester_if bus();

   apb_requester #(.RD_DELAY(1), .TIMEOUT(TIMEOUT)) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus)
   );

   // ---------------- target model ----------------
   logic [31:0] regs [0:4] = '{default: 32'h0};
   bit          stuck    = 1'b0;   // pready held low forever
   int          wait_req = 0;      // wait states for the next transfer
   int          wait_ctr = 0;

   assign bus.pready = !stuck && (wait_ctr == 0);

   function automatic bit in_range(input logic [31:0] a);
      return (a < 32'h14) && (a[1:0] == 2'b00);
   endfunction

   always @(posedge pclk) begin
      if (bus.psel && !bus.penable) begin
         wait_ctr <= wait_req;
      end else if (bus.psel && bus.penable) begin
         if (!bus.pready) begin
            if (wait_ctr > 0) wait_ctr <= wait_ctr - 1;
         end else if (bus.pwrite) begin
            if (in_range(bus.paddr)) begin
               if (bus.paddr[4:2] == 3'd0) regs[0] <= {28'h0, bus.pwdata[3:0]};
               else                        regs[bus.paddr[4:2]] <= bus.pwdata;
            end
         end else begin
            // Registered read data: valid the cycle after ACCESS completes.
            bus.prdata <= in_range(bus.paddr) ? regs[bus.paddr[4:2]] : 32'h0;
         end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one command; lat is cycles from the accepting edge to rsp_valid
   // (-1 if none), acc counts ACCESS cycles, stable says paddr/pwrite/pwdata
   // held the command values throughout ACCESS.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int acc, output logic stable);
      int n;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge pclk);
         n++;
      end
      @(posedge pclk);
      #1 bus.cmd_valid = 1'b0;
      lat    = -1;
      rdata  = 32'hx;
      err    = 1'bx;
      acc    = 0;
      stable = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge pclk);
         if (bus.psel && bus.penable) begin
            acc++;
            if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) stable = 1'b0;
         end
         if (bus.rsp_valid) begin
            lat   = c;
            rdata = bus.rsp_rdata;
            err   = bus.rsp_error;
            break;
         end
      end
   endtask

   int          lat, acc;
   logic [31:0] rd;
   logic        er, st;
   logic        seen;
   int          acc_i [3];
   int          rsp_i [3];
   int          na, nr;
   logic [31:0] bb_addr [3] = '{32'h8, 32'hC, 32'h10};
   logic [31:0] bb_data [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = 32'h0;

      // Reset values
      #2 presetn = 1'b0;
      repeat (2) @(negedge pclk);
      chk("rst_ctl", {31'h0, bus.cmd_ready}, 32'h1);
      chk("rst_sel", {30'h0, bus.psel, bus.penable}, 32'h0);
      chk("rst_bus", {bus.paddr | bus.pwdata | {31'h0, bus.pwrite}}, 32'h0);
      chk("rst_rsp", {bus.rsp_rdata | {30'h0, bus.rsp_valid, bus.rsp_error}}, 32'h0);
      presetn = 1'b1;

      // Write then read back
      run_cmd(1'b1, 32'h4, 32'hDEADBEEF, lat, rd, er, acc, st);
      chk("wr4_lat", lat, 3);
      chk("wr4_err", er, 0);
      chk("wr4_rdata", rd, 32'h0);
      run_cmd(1'b0, 32'h4, 32'h0, lat, rd, er, acc, st);
      chk("rd4_lat", lat, 4);
      chk("rd4_rdata", rd, 32'hDEADBEEF);
      chk("rd4_err", er, 0);

      // Narrow register and unmapped address
      run_cmd(1'b1, 32'h0, 32'hFFFFFFFF, lat, rd, er, acc, st);
      chk("wr0_lat", lat, 3);
      run_cmd(1'b0, 32'h0, 32'h0, lat, rd, er, acc, st);
      chk("rd0_rdata", rd, 32'h0000000F);
      run_cmd(1'b0, 32'h20, 32'h0, lat, rd, er, acc, st);
      chk("rd20_rdata", rd, 32'h0);
      chk("rd20_err", er, 0);

      // Three wait states on a read
      run_cmd(1'b1, 32'h8, 32'h12345678, lat, rd, er, acc, st);
      wait_req = 3;
      run_cmd(1'b0, 32'h8, 32'h0, lat, rd, er, acc, st);
      wait_req = 0;
      chk("ws_acc", acc, 4);
      chk("ws_stable", st, 1);
      chk("ws_lat", lat, 7);
      chk("ws_rdata", rd, 32'h12345678);

      // Timeout with pready stuck low
      stuck = 1'b1;
      run_cmd(1'b0, 32'h4, 32'h0, lat, rd, er, acc, st);
      chk("to_acc", acc, TIMEOUT);
      chk("to_lat", lat, TIMEOUT + 2);
      chk("to_err", er, 1);
      chk("to_rdata", rd, 32'h0);
      chk("to_stable", st, 1);
      @(negedge pclk);
      chk("to_ready", bus.cmd_ready, 1);
      stuck = 1'b0;

      // Reset during the first ACCESS cycle
      @(negedge pclk);
      chk("ar_ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h10;
      bus.cmd_wdata = 32'hA5A5A5A5;
      @(posedge pclk);
      #1 bus.cmd_valid = 1'b0;
      @(posedge pclk);
      #2;
      chk("ar_in_access", {30'h0, bus.psel, bus.penable}, 32'h3);
      presetn = 1'b0;
      #1;
      chk("ar_sel_drop", {30'h0, bus.psel, bus.penable}, 32'h0);
      chk("ar_bus", {bus.paddr | bus.pwdata | {31'h0, bus.pwrite}}, 32'h0);
      chk("ar_rsp", {bus.rsp_rdata | {30'h0, bus.rsp_valid, bus.rsp_error}}, 32'h0);
      seen = 1'b0;
      repeat (2) begin
         @(negedge pclk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      presetn = 1'b1;
      repeat (6) begin
         @(negedge pclk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      chk("ar_no_rsp", seen, 0);
      chk("ar_ready_after", bus.cmd_ready, 1);
      run_cmd(1'b0, 32'h10, 32'h0, lat, rd, er, acc, st);
      chk("ar_no_write", rd, 32'h0);

      // Back-to-back writes with cmd_valid held high
      na = 0;
      nr = 0;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = bb_addr[0];
      bus.cmd_wdata = bb_data[0];
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge pclk);
         if (bus.rsp_valid && nr < 3) begin
            rsp_i[nr] = c;
            nr++;
         end
         if (bus.cmd_valid && bus.cmd_ready && na < 3) begin
            acc_i[na] = c;
            na++;
            @(posedge pclk);
            #1;
            if (na < 3) begin
               bus.cmd_addr  = bb_addr[na];
               bus.cmd_wdata = bb_data[na];
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
      end
      bus.cmd_valid = 1'b0;
      chk("bb_naccept", na, 3);
      chk("bb_nrsp", nr, 3);
      if (na == 3 && nr == 3) begin
         chk("bb_acc_gap1", acc_i[1] - acc_i[0], 4);
         chk("bb_acc_gap2", acc_i[2] - acc_i[1], 4);
         chk("bb_rsp_lat", rsp_i[0] - acc_i[0], 3);
         chk("bb_rsp_gap1", rsp_i[1] - rsp_i[0], 4);
         chk("bb_rsp_gap2", rsp_i[2] - rsp_i[1], 4);
      end
      run_cmd(1'b0, 32'hC, 32'h0, lat, rd, er, acc, st);
      chk("bb_rdC", rd, 32'h22222222);
      run_cmd(1'b0, 32'h10, 32'h0, lat, rd, er, acc, st);
      chk("bb_rd10", rd, 32'h33333333);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
